// File: rtl/eth_tx_mac.sv
`default_nettype none
// ============================================================================
// Module   : eth_tx_mac
// Brief    : GMII transmit MAC - preamble/SFD, padding, CRC-32 FCS, IFG.
// Revision : 1.0 - initial release
// ============================================================================
module eth_tx_mac #(
    parameter int IFG_CYCLES = 12,
    parameter int MIN_FRAME  = 60,
    parameter int MAX_FRAME  = 1514
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] gmii_txd,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er,
    output logic       busy,
    output logic       frame_done,
    output logic       frame_err
);
    localparam logic [2:0] c_idle        = 3'd0;
    localparam logic [2:0] c_preamble    = 3'd1;
    localparam logic [2:0] c_data        = 3'd2;
    localparam logic [2:0] c_pad         = 3'd3;
    localparam logic [2:0] c_fcs         = 3'd4;
    localparam logic [2:0] c_abort_drain = 3'd5;
    localparam logic [2:0] c_ifg         = 3'd6;

    localparam logic [10:0] c_min_frame = 11'(MIN_FRAME);
    localparam logic [10:0] c_max_frame = 11'(MAX_FRAME);
    localparam logic [15:0] c_ifg_last  = 16'(IFG_CYCLES - 1);
    localparam logic [31:0] c_crc_poly  = 32'hEDB8_8320;
    localparam logic [31:0] c_crc_init  = 32'hFFFF_FFFF;

    logic [2:0]  r_state;
    logic [2:0]  r_pre_cnt;
    logic [1:0]  r_fcs_idx;
    logic [10:0] r_byte_cnt;
    logic [15:0] r_ifg_cnt;
    logic [31:0] r_crc;

    logic [31:0] w_crc_data;
    logic [31:0] w_crc_pad;
    logic [10:0] w_cnt_inc;
    logic [7:0]  w_fcs_byte;
    logic        w_sfd_slot;

    // Reflected CRC-32, one byte per call, LSB of the byte first.
    function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ c_crc_poly) : (c >> 1);
        end
        return c;
    endfunction

    assign w_crc_data = crc_step(r_crc, in_data);
    assign w_crc_pad  = crc_step(r_crc, 8'h00);
    assign w_cnt_inc  = r_byte_cnt + 11'd1;
    assign w_fcs_byte = ~r_crc[{r_fcs_idx, 3'b000} +: 8];
    assign w_sfd_slot = (r_state == c_preamble) && (r_pre_cnt == 3'd7);

    // The SFD cycle doubles as the first acceptance slot so byte 1 follows 0xD5 directly.
    assign in_ready = w_sfd_slot
                    || ((r_state == c_data) && (r_byte_cnt != c_max_frame))
                    || (r_state == c_abort_drain);
    assign busy     = (r_state != c_idle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_idle;
            r_pre_cnt  <= 3'd0;
            r_fcs_idx  <= 2'd0;
            r_byte_cnt <= 11'd0;
            r_ifg_cnt  <= 16'd0;
            r_crc      <= c_crc_init;
            gmii_txd   <= 8'h00;
            gmii_tx_en <= 1'b0;
            gmii_tx_er <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            gmii_tx_er <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            case (r_state)
                c_idle: begin
                    gmii_txd   <= 8'h00;
                    gmii_tx_en <= 1'b0;
                    if (in_valid) begin
                        r_state    <= c_preamble;
                        r_pre_cnt  <= 3'd0;
                        r_fcs_idx  <= 2'd0;
                        r_byte_cnt <= 11'd0;
                        r_crc      <= c_crc_init;
                        gmii_txd   <= 8'h55;
                        gmii_tx_en <= 1'b1;
                    end
                end
                c_preamble, c_data: begin
                    if ((r_state == c_preamble) && !w_sfd_slot) begin
                        r_pre_cnt <= r_pre_cnt + 3'd1;
                        gmii_txd  <= (r_pre_cnt == 3'd6) ? 8'hD5 : 8'h55;
                    end else if (in_valid && in_ready) begin
                        gmii_txd   <= in_data;
                        gmii_tx_en <= 1'b1;
                        r_crc      <= w_crc_data;
                        r_byte_cnt <= w_cnt_inc;
                        if (in_last) begin
                            r_state <= (w_cnt_inc < c_min_frame) ? c_pad : c_fcs;
                        end else begin
                            r_state <= c_data;
                        end
                    end else begin
                        // Underrun or oversize: one error-propagation byte, then drain.
                        gmii_txd   <= 8'h00;
                        gmii_tx_en <= 1'b1;
                        gmii_tx_er <= 1'b1;
                        frame_err  <= 1'b1;
                        r_state    <= c_abort_drain;
                    end
                end
                c_pad: begin
                    gmii_txd   <= 8'h00;
                    r_crc      <= w_crc_pad;
                    r_byte_cnt <= w_cnt_inc;
                    if (w_cnt_inc >= c_min_frame) begin
                        r_state <= c_fcs;
                    end
                end
                c_fcs: begin
                    gmii_txd  <= w_fcs_byte;
                    r_fcs_idx <= r_fcs_idx + 2'd1;
                    if (r_fcs_idx == 2'd3) begin
                        frame_done <= 1'b1;
                        r_ifg_cnt  <= 16'd0;
                        r_state    <= c_ifg;
                    end
                end
                c_abort_drain: begin
                    gmii_txd   <= 8'h00;
                    gmii_tx_en <= 1'b0;
                    if (in_valid && in_last) begin
                        r_ifg_cnt <= 16'd0;
                        r_state   <= c_ifg;
                    end
                end
                c_ifg: begin
                    gmii_txd   <= 8'h00;
                    gmii_tx_en <= 1'b0;
                    if (r_ifg_cnt == c_ifg_last) begin
                        r_state <= c_idle;
                    end else begin
                        r_ifg_cnt <= r_ifg_cnt + 16'd1;
                    end
                end
                default: begin
                    gmii_txd   <= 8'h00;
                    gmii_tx_en <= 1'b0;
                    r_state    <= c_idle;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_eth_tx_mac.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_eth_tx_mac
// Brief    : Self-checking bench for eth_tx_mac (MIN_FRAME=0 and default DUTs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_tx_mac;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;

    logic [7:0] a_txd, b_txd;
    logic a_ready, a_en, a_er, a_busy, a_done, a_err;
    logic b_ready, b_en, b_er, b_busy, b_done, b_err;

    always #5 clk = ~clk;

    eth_tx_mac #(.IFG_CYCLES(12), .MIN_FRAME(0), .MAX_FRAME(1514)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(a_ready), .gmii_txd(a_txd), .gmii_tx_en(a_en), .gmii_tx_er(a_er),
        .busy(a_busy), .frame_done(a_done), .frame_err(a_err)
    );

    eth_tx_mac u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(b_ready), .gmii_txd(b_txd), .gmii_tx_en(b_en), .gmii_tx_er(b_er),
        .busy(b_busy), .frame_done(b_done), .frame_err(b_err)
    );

    typedef struct {
        logic [7:0] d;
        logic       v;
        logic       l;
        logic [7:0] txd;
        logic       en;
        logic       done;
        logic       rdy;
        logic       bsy;
    } vec_t;

    vec_t       vt [0:22];
    int         checks = 0;
    int         failures = 0;
    logic [7:0] tx_buf  [0:2047];
    logic [7:0] exp_mem [0:2047];
    int         exp_len = 0;

    // Frame capture on the default DUT; tx_er cycles are kept out of the byte log.
    logic [7:0] cap_mem [0:4095];
    int   cap_ptr = 0;
    int   fr_start[$], fr_len[$], fr_gap[$], fr_done[$];
    bit   in_frame = 1'b0;
    int   gap_cnt = 0, cur_start = 0, cur_done = -1, cur_gap = 0;
    int   done_total = 0, err_total = 0, er_total = 0;
    logic [7:0] er_txd = 8'h00;
    logic er_err_same = 1'b0;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            in_frame = 1'b0;
            gap_cnt  = 0;
        end else begin
            if (b_done) done_total++;
            if (b_err) err_total++;
            if (b_er) begin
                er_total++;
                er_txd = b_txd;
                er_err_same = b_err;
            end
            if (b_en) begin
                if (!in_frame) begin
                    in_frame = 1'b1;
                    cur_start = cap_ptr;
                    cur_done = -1;
                    cur_gap = gap_cnt;
                end
                if (!b_er) begin
                    cap_mem[cap_ptr] = b_txd;
                    if (b_done) cur_done = cap_ptr - cur_start;
                    cap_ptr++;
                end
            end else if (in_frame) begin
                fr_start.push_back(cur_start);
                fr_len.push_back(cap_ptr - cur_start);
                fr_gap.push_back(cur_gap);
                fr_done.push_back(cur_done);
                in_frame = 1'b0;
                gap_cnt = 1;
            end else begin
                gap_cnt++;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic send(input int off, input int n, input int last_at, output int cyc);
        int   i;
        logic rdy;
        i = 0;
        cyc = 0;
        while (i < n && cyc < 4000) begin
            in_valid = 1'b1;
            in_data  = tx_buf[off + i];
            in_last  = (i == last_at);
            @(negedge clk);
            rdy = b_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (rdy) i++;
        end
        if (i < n) chk("send_timeout", i, n);
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic wait_frames(input int target);
        int t;
        t = 0;
        while (fr_len.size() < target && t < 5000) begin
            @(posedge clk);
            t++;
        end
        if (fr_len.size() < target) chk("frame_timeout", fr_len.size(), target);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (b_busy && t < 5000) begin
            @(posedge clk);
            t++;
        end
        chk("idle_timeout", b_busy, 0);
        @(posedge clk);
        #1;
    endtask

    // Expected wire image: preamble, payload, optional zero pad to 60 and FCS.
    task automatic build_exp(input int off, input int n, input bit with_fcs);
        logic [31:0] crc;
        logic [7:0]  b;
        logic        fb;
        int          len;
        exp_len = 0;
        for (int i = 0; i < 7; i++) begin
            exp_mem[exp_len] = 8'h55;
            exp_len++;
        end
        exp_mem[exp_len] = 8'hD5;
        exp_len++;
        crc = 32'hFFFF_FFFF;
        len = (with_fcs && n < 60) ? 60 : n;
        for (int i = 0; i < len; i++) begin
            b = (i < n) ? tx_buf[off + i] : 8'h00;
            exp_mem[exp_len] = b;
            exp_len++;
            for (int j = 0; j < 8; j++) begin
                fb  = crc[0] ^ b[j];
                crc = {1'b0, crc[31:1]};
                if (fb) crc = crc ^ 32'hEDB8_8320;
            end
        end
        if (with_fcs) begin
            crc = ~crc;
            for (int j = 0; j < 4; j++) begin
                exp_mem[exp_len] = crc[8*j +: 8];
                exp_len++;
            end
        end
    endtask

    task automatic check_frame(input string nm, input int k);
        int mism;
        int first;
        if (k >= fr_len.size()) return;
        chk({nm, "_len"}, fr_len[k], exp_len);
        mism = 0;
        first = -1;
        for (int i = 0; i < exp_len && i < fr_len[k]; i++) begin
            if (cap_mem[fr_start[k] + i] !== exp_mem[i]) begin
                if (first < 0) first = i;
                mism++;
            end
        end
        if (mism != 0) $display("first bad byte of %s at index %0d", nm, first);
        chk({nm, "_bytes_bad"}, mism, 0);
    endtask

    initial begin
        int cyc, fidx, e0, r0, d0;

        for (int r = 0; r < 23; r++) begin
            vt[r].d    = 8'h31;
            vt[r].v    = 1'b1;
            vt[r].l    = 1'b0;
            vt[r].txd  = 8'h00;
            vt[r].en   = (r >= 1 && r <= 21);
            vt[r].done = (r == 21);
            vt[r].rdy  = (r >= 8 && r <= 16);
            vt[r].bsy  = (r >= 1);
            if (r >= 1 && r <= 7) vt[r].txd = 8'h55;
            if (r == 8) vt[r].txd = 8'hD5;
            if (r >= 9 && r <= 17) vt[r].txd = 8'(8'h31 + (r - 9));
        end
        for (int k = 0; k < 8; k++) vt[9 + k].d = 8'(8'h32 + k);
        vt[16].l = 1'b1;
        for (int r = 17; r < 23; r++) begin
            vt[r].v = 1'b0;
            vt[r].d = 8'h00;
        end
        vt[18].txd = 8'h26;
        vt[19].txd = 8'h39;
        vt[20].txd = 8'hF4;
        vt[21].txd = 8'hCB;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_a", {a_txd, a_en, a_er, a_done, a_err, a_ready, a_busy}, 0);
        chk("reset_b", {b_txd, b_en, b_er, b_done, b_err, b_ready, b_busy}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // "123456789" on the MIN_FRAME=0 instance, cycle by cycle
        for (int r = 0; r < 23; r++) begin
            @(posedge clk);
            #1;
            in_data  = vt[r].d;
            in_valid = vt[r].v;
            in_last  = vt[r].l;
            @(negedge clk);
            chk($sformatf("vec_row%0d", r),
                {a_txd, a_en, a_er, a_done, a_err, a_ready, a_busy},
                {vt[r].txd, vt[r].en, 1'b0, vt[r].done, 1'b0, vt[r].rdy, vt[r].bsy});
        end
        idle_inputs();

        // Same 9 bytes on the default instance are padded to 60
        fidx = 0;
        for (int i = 0; i < 9; i++) tx_buf[i] = 8'(8'h31 + i);
        wait_frames(fidx + 1);
        build_exp(0, 9, 1'b1);
        check_frame("pad9", fidx);
        if (fidx < fr_done.size()) chk("pad9_done_idx", fr_done[fidx], exp_len - 1);
        fidx++;
        wait_idle();

        // 14-byte header, then a 64-byte frame back to back with in_valid held
        tx_buf[0] = 8'hAA; tx_buf[1] = 8'hBB; tx_buf[2] = 8'hCC;
        tx_buf[3] = 8'hDD; tx_buf[4] = 8'hEE; tx_buf[5] = 8'hFF;
        tx_buf[6] = 8'h00; tx_buf[7] = 8'h0A; tx_buf[8] = 8'h35;
        tx_buf[9] = 8'h01; tx_buf[10] = 8'h02; tx_buf[11] = 8'h03;
        tx_buf[12] = 8'h08; tx_buf[13] = 8'h00;
        for (int i = 0; i < 64; i++) tx_buf[100 + i] = 8'(i * 7 + 3);
        send(0, 14, 13, cyc);
        send(100, 64, 63, cyc);
        idle_inputs();
        wait_frames(fidx + 2);
        build_exp(0, 14, 1'b1);
        check_frame("hdr14", fidx);
        if (fidx < fr_done.size()) chk("hdr14_done_idx", fr_done[fidx], 71);
        fidx++;
        build_exp(100, 64, 1'b1);
        check_frame("b2b64", fidx);
        if (fidx < fr_gap.size()) chk("b2b_gap", fr_gap[fidx], 12);
        if (fidx < fr_done.size()) chk("b2b64_done_idx", fr_done[fidx], 75);
        fidx++;
        wait_idle();

        // Underrun after 20 bytes, then drain 5 bytes
        e0 = er_total; r0 = err_total; d0 = done_total;
        for (int i = 0; i < 20; i++) tx_buf[200 + i] = 8'(8'hC0 + i);
        for (int i = 0; i < 5; i++) tx_buf[300 + i] = 8'(8'hE0 + i);
        send(200, 20, -1, cyc);
        idle_inputs();
        @(posedge clk);
        #1;
        send(300, 5, 4, cyc);
        idle_inputs();
        chk("drain_cycles", cyc, 5);
        wait_frames(fidx + 1);
        build_exp(200, 20, 1'b0);
        check_frame("underrun", fidx);
        fidx++;
        chk("underrun_er_cycles", er_total - e0, 1);
        chk("underrun_err_pulses", err_total - r0, 1);
        chk("underrun_er_txd", er_txd, 8'h00);
        chk("underrun_err_with_er", er_err_same, 1'b1);
        chk("underrun_no_done", done_total - d0, 0);
        wait_idle();

        // 1515 bytes without last inside MAX_FRAME
        e0 = er_total; r0 = err_total; d0 = done_total;
        for (int i = 0; i < 1515; i++) tx_buf[i] = 8'(i * 13 + 5);
        send(0, 1515, 1514, cyc);
        idle_inputs();
        wait_frames(fidx + 1);
        build_exp(0, 1514, 1'b0);
        check_frame("oversize", fidx);
        fidx++;
        chk("oversize_er_cycles", er_total - e0, 1);
        chk("oversize_err_pulses", err_total - r0, 1);
        chk("oversize_no_done", done_total - d0, 0);
        wait_idle();

        // Reset in the middle of DATA
        in_data  = 8'hA5;
        in_valid = 1'b1;
        in_last  = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        chk("pre_reset_tx_en", b_en, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset_b", {b_txd, b_en, b_er, b_done, b_err, b_ready, b_busy}, 0);
        chk("midreset_a", {a_txd, a_en, a_er, a_done, a_err, a_ready, a_busy}, 0);
        idle_inputs();
        #22;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        d0 = done_total;
        for (int i = 0; i < 60; i++) tx_buf[i] = 8'(i ^ 8'h5A);
        send(0, 60, 59, cyc);
        idle_inputs();
        wait_frames(fidx + 1);
        build_exp(0, 60, 1'b1);
        check_frame("post_reset", fidx);
        if (fidx < fr_done.size()) chk("post_reset_done_idx", fr_done[fidx], 71);
        chk("post_reset_done_count", done_total - d0, 1);
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/eth_tx_mac.md
Name: eth_tx_mac

Overview:
- Downstream stage of the Ethernet header/payload byte generator.
- Takes a byte stream and produces a complete on-wire GMII-style transmit stream:
  - 7-byte preamble and SFD
  - header/payload bytes passed through
  - zero padding to minimum frame length
  - CRC-32 FCS
  - enforced inter-frame gap
- Sole driver of the PHY transmit byte interface.

Parameters:
- IFG_CYCLES, 12: idle cycles (tx_en=0) after the last FCS byte before the next frame may start.
- MIN_FRAME, 60: minimum bytes (DA through pad, FCS excluded); shorter frames are zero-padded.
- MAX_FRAME, 1514: maximum bytes (FCS excluded) accepted before abort.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_data  in  8  frame byte, starting with destination MAC MSB.
- in_valid  in  1  in_data valid.
- in_last  in  1  marks final byte of the frame; qualified by in_valid.
- in_ready  out  1  block accepts a byte on the edge where in_valid & in_ready.
- gmii_txd  out  8  transmit byte to PHY.
- gmii_tx_en  out  1  transmit enable.
- gmii_tx_er  out  1  transmit error (abort marker).
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse on the cycle the final FCS byte is driven.
- frame_err  out  1  one-cycle pulse on the cycle tx_er is driven.

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE; all outputs 0 (gmii_txd=0x00, tx_en/tx_er/in_ready/busy/frame_done/frame_err=0); CRC=0xFFFFFFFF; counters 0. Reset mid-frame cuts tx_en immediately; no FCS is sent.
- All gmii_* outputs are registered.
- States: IDLE, PREAMBLE, DATA, PAD, FCS, ABORT_DRAIN, IFG.
- IDLE:
  - in_ready=0.
  - in_valid=1 sampled high -> PREAMBLE. The first byte is not consumed yet.
- PREAMBLE:
  - txd = 0x55 for 7 cycles, then 0xD5 for 1 cycle; tx_en=1 throughout.
  - in_ready=1 only during the cycle 0xD5 is on txd.
- Data transfer:
  - A byte accepted on edge k appears on txd in the cycle following edge k.
  - tx_en stays continuously high from the first 0x55 through the last FCS byte.
- DATA:
  - in_ready=1 while in DATA and not yet at in_last.
  - Each accepted byte feeds the CRC; the 11-bit byte_count increments.
  - in_valid=0 with in_ready=1 is an underrun:
    - next cycle txd=0x00, tx_er=1, frame_err pulse;
    - state -> ABORT_DRAIN.
  - byte_count reaches MAX_FRAME without in_last: same abort path as underrun.
  - Accepted byte has in_last=1: in_ready drops the following cycle.
    - byte_count < MIN_FRAME -> PAD.
    - otherwise -> FCS.
- PAD:
  - txd=0x00, included in the CRC, until byte_count == MIN_FRAME, then -> FCS.
  - in_ready=0.
- FCS:
  - CRC-32: polynomial 0x04C11DB7, reflected (LSB-first) form, init 0xFFFFFFFF, over DA..pad.
  - FCS = bitwise NOT of the final CRC, sent as 4 bytes, least-significant byte first.
  - frame_done pulses with the 4th byte, then -> IFG.
- ABORT_DRAIN:
  - tx_en=0, in_ready=1.
  - Discards input bytes until an accepted byte with in_last=1, then -> IFG.
- IFG:
  - tx_en=0, in_ready=0 for exactly IFG_CYCLES cycles, then -> IDLE.
  - in_valid held high during IFG is honoured on the first IDLE cycle.
- in_valid=1 in IDLE together with in_last=1 (1-byte frame) is legal; the frame is padded to MIN_FRAME.
- busy=1 from the edge leaving IDLE until re-entry to IDLE.

Test Plan:
- MIN_FRAME=0, send ASCII "123456789" (0x31..0x39, last on 0x39) -> txd: 7×0x55, 0xD5, 0x31..0x39, 0x26, 0x39, 0xF4, 0xCB; tx_en high for 21 contiguous cycles; frame_done on the 0xCB cycle.
- Default params, 14-byte header (DA AA:BB:CC:DD:EE:FF, SA 00:0A:35:01:02:03, type 0x0800), last on byte 14 -> 46 bytes of 0x00 pad follow, FCS over 60 bytes, 72 tx_en cycles total, then exactly 12 tx_en=0 cycles before the next frame's first 0x55.
- Back-to-back frames with in_valid held high -> the gap between tx_en falling and rising is exactly IFG_CYCLES; no byte lost or duplicated.
- Drop in_valid after 20 bytes (no last) -> one cycle txd=0x00 with tx_er=1, frame_err pulse, no FCS; remaining bytes up to in_last are discarded with in_ready=1; then IFG.
- Send 1515 bytes without last -> abort with tx_er after byte 1514; frame_done never pulses.
- Assert rst_n=0 mid-DATA -> all outputs 0 asynchronously; after release, a new frame transmits correctly with a correct FCS.
